// File: rtl/regbank_pkg.sv
// Shared constants, types and helpers for the register bank write path.
package regbank_pkg;

  localparam int AW = 6;
  localparam int DW = 16;

  localparam logic [AW-1:0] REG_GPR_LAST = 6'd27;
  localparam logic [AW-1:0] REG_PI0      = 6'd28;
  localparam logic [AW-1:0] REG_PI1      = 6'd29;
  localparam logic [AW-1:0] REG_PO0      = 6'd30;
  localparam logic [AW-1:0] REG_PO1      = 6'd31;
  localparam logic [AW-1:0] REG_W        = 6'd34;
  localparam logic [AW-1:0] REG_NONE     = 6'd35;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Writable targets: general registers, the two output ports and W.
  // The input ports (PI0/PI1), 32, 33 and everything from REG_NONE up are read-only or unmapped.
  function automatic logic is_writable(input logic [AW-1:0] sel);
    return (sel <= REG_GPR_LAST) || (sel == REG_PO0) || (sel == REG_PO1) || (sel == REG_W);
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module regbank_write_arbiter_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   idx;

  // Scan NREQ positions starting at ptr; the first valid request wins.
  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the register bank's single write port among NREQ requesters.
// Round-robin grant with an optional bounded lock; illegal targets are dropped and flagged.
module regbank_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int DW       = regbank_pkg::DW,
  parameter int AW       = regbank_pkg::AW,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*AW-1:0] req_sel,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_sel,
  output logic [DW-1:0]     wr_data,
  output logic [NREQ-1:0]   gnt_onehot,
  output logic              err_pulse,
  output logic [NREQ-1:0]   err_src,
  output logic              lock_timeout
);

  import regbank_pkg::*;

  localparam int         PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  arb_state_t    state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [7:0]    lock_cnt, lock_cnt_n;
  logic          timeout_n;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   win_idx;
  logic            xfer;
  logic            legal;
  logic [AW-1:0]   win_sel;
  logic [DW-1:0]   win_data;
  logic            win_lock;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == NREQ - 1) ? '0 : p + PW'(1);
  endfunction

  regbank_write_arbiter_rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_rr_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(pick)
  );

  // Grant: round-robin pick when idle, owner only when locked, nothing while in reset.
  always_comb begin
    req_ready = '0;
    if (!reset) begin
      if (state == IDLE) req_ready = pick;
      else if (req_valid[owner]) req_ready[owner] = 1'b1;
    end
  end

  // Decode the winning requester and its payload.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) win_idx = PW'(i);
    end
    xfer     = |req_ready;
    win_sel  = req_sel[int'(win_idx)*AW +: AW];
    win_data = req_data[int'(win_idx)*DW +: DW];
    win_lock = req_lock[win_idx];
    legal    = is_writable(win_sel);
  end

  // Lock FSM, lock counter and round-robin pointer next-state.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    lock_cnt_n = lock_cnt;
    ptr_n      = ptr;
    timeout_n  = 1'b0;
    if (xfer) ptr_n = next_ptr(win_idx);
    case (state)
      IDLE: begin
        if (xfer && legal && win_lock) begin
          state_n    = LOCKED;
          owner_n    = win_idx;
          lock_cnt_n = 8'd1;
        end
      end
      LOCKED: begin
        lock_cnt_n = (lock_cnt >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt + 8'd1;
        if (!req_lock[owner]) begin
          state_n    = IDLE;
          lock_cnt_n = 8'd0;
        end else if (lock_cnt_n == LOCK_MAX_C) begin
          state_n    = IDLE;
          lock_cnt_n = 8'd0;
          timeout_n  = 1'b1;
          ptr_n      = next_ptr(owner);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // Registered bank write port and status pulses; sel/data only move on a legal transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en        <= 1'b0;
      wr_sel       <= REG_NONE;
      wr_data      <= '0;
      gnt_onehot   <= '0;
      err_pulse    <= 1'b0;
      err_src      <= '0;
      lock_timeout <= 1'b0;
    end else begin
      wr_en        <= xfer && legal;
      gnt_onehot   <= req_ready;
      err_pulse    <= xfer && !legal;
      err_src      <= (xfer && !legal) ? req_ready : '0;
      lock_timeout <= timeout_n;
      if (xfer && legal) begin
        wr_sel  <= win_sel;
        wr_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter (NREQ=3, LOCK_MAX=8).
module tb_regbank_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ*AW-1:0] req_sel;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_sel;
  logic [DW-1:0]     wr_data;
  logic [NREQ-1:0]   gnt_onehot;
  logic              err_pulse;
  logic [NREQ-1:0]   err_src;
  logic              lock_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  regbank_write_arbiter #(
    .NREQ(NREQ), .DW(DW), .AW(AW), .LOCK_MAX(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_lock(req_lock), .req_sel(req_sel), .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .gnt_onehot(gnt_onehot), .err_pulse(err_pulse), .err_src(err_src),
    .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [AW-1:0] s, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_lock[i]           = l;
    req_sel[i*AW +: AW]   = s;
    req_data[i*DW +: DW]  = d;
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] s,
                          input logic [DW-1:0] d, input logic [NREQ-1:0] g);
    check({tag, "_wr_en"}, 32'(wr_en), 32'(en));
    check({tag, "_wr_sel"}, 32'(wr_sel), 32'(s));
    check({tag, "_wr_data"}, 32'(wr_data), 32'(d));
    check({tag, "_gnt"}, 32'(gnt_onehot), 32'(g));
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;

    // T1: reset held two cycles with every requester valid.
    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_sel = '0; req_data = '0;
    set_req(0, 1'b1, 1'b0, 6'd5, 16'h0100);
    set_req(1, 1'b1, 1'b0, 6'd6, 16'h0101);
    set_req(2, 1'b1, 1'b0, 6'd7, 16'h0102);
    #1;
    check("t1_ready_rst0", 32'(req_ready), 32'h0);
    tick();
    check("t1_ready_rst1", 32'(req_ready), 32'h0);
    tick();
    check_wr("t1_rst", 1'b0, 6'd35, 16'h0000, 3'b000);
    check("t1_err_pulse", 32'(err_pulse), 32'h0);
    check("t1_err_src", 32'(err_src), 32'h0);
    check("t1_timeout", 32'(lock_timeout), 32'h0);
    reset = 1'b0;

    // T2: all valid, winners rotate 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      #1;
      check("t2_ready", 32'(req_ready), 32'(exp_g));
      tick();
      check_wr("t2", 1'b1, 6'(5 + k % 3), 16'(16'h0100 + k % 3), exp_g);
    end

    // Idle cycle: no strobe, bank select/data hold.
    req_valid = '0;
    #1;
    check("t2_idle_ready", 32'(req_ready), 32'h0);
    tick();
    check_wr("t2_idle", 1'b0, 6'd7, 16'h0102, 3'b000);

    // T3: illegal target from req1 is handshaken then dropped.
    set_req(1, 1'b1, 1'b0, 6'd28, 16'hBEEF);
    #1;
    check("t3_ready_ill", 32'(req_ready), 32'h2);
    tick();
    check_wr("t3_ill", 1'b0, 6'd7, 16'h0102, 3'b010);
    check("t3_err_pulse", 32'(err_pulse), 32'h1);
    check("t3_err_src", 32'(err_src), 32'h2);
    set_req(1, 1'b1, 1'b0, 6'd34, 16'hBEEF);
    #1;
    check("t3_ready_w", 32'(req_ready), 32'h2);
    tick();
    check_wr("t3_w", 1'b1, 6'd34, 16'hBEEF, 3'b010);
    check("t3_err_clear", 32'(err_pulse), 32'h0);

    // T4: req2 locks for PO0 then PO1 while req0 waits (pointer now at 2).
    req_valid = '0;
    set_req(0, 1'b1, 1'b0, 6'd1, 16'h0001);
    set_req(2, 1'b1, 1'b1, 6'd30, 16'hA0A0);
    #1;
    check("t4_ready_po0", 32'(req_ready), 32'h4);
    tick();
    check_wr("t4_po0", 1'b1, 6'd30, 16'hA0A0, 3'b100);
    set_req(2, 1'b1, 1'b0, 6'd31, 16'hA1A1);
    #1;
    check("t4_ready_po1", 32'(req_ready), 32'h4);
    tick();
    check_wr("t4_po1", 1'b1, 6'd31, 16'hA1A1, 3'b100);
    #1;
    check("t4_ready_req0", 32'(req_ready), 32'h1);
    tick();
    check_wr("t4_req0", 1'b1, 6'd1, 16'h0001, 3'b001);

    // T5: req1 holds its lock; forced release after 8 writes, then req2 wins.
    set_req(0, 1'b0, 1'b0, 6'd1, 16'h0001);
    set_req(2, 1'b1, 1'b0, 6'd12, 16'h2222);
    for (int k = 0; k < 8; k++) begin
      set_req(1, 1'b1, 1'b1, 6'd10, 16'(16'h5500 + k));
      #1;
      check("t5_ready_lock", 32'(req_ready), 32'h2);
      tick();
      check_wr("t5_lock", 1'b1, 6'd10, 16'(16'h5500 + k), 3'b010);
      check("t5_timeout", 32'(lock_timeout), (k == 7) ? 32'h1 : 32'h0);
    end
    #1;
    check("t5_ready_after", 32'(req_ready), 32'h4);
    tick();
    check_wr("t5_after", 1'b1, 6'd12, 16'h2222, 3'b100);
    check("t5_timeout_clear", 32'(lock_timeout), 32'h0);

    // T6: reset while locked with a transfer pending; req0 wins first afterwards.
    req_valid = '0;
    set_req(2, 1'b1, 1'b1, 6'd20, 16'h6666);
    #1;
    check("t6_ready_lock", 32'(req_ready), 32'h4);
    tick();
    check_wr("t6_lock", 1'b1, 6'd20, 16'h6666, 3'b100);
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 6'd2, 16'h0002);
    set_req(1, 1'b1, 1'b0, 6'd3, 16'h0003);
    set_req(2, 1'b1, 1'b1, 6'd21, 16'h7777);
    #1;
    check("t6_ready_rst", 32'(req_ready), 32'h0);
    tick();
    check_wr("t6_rst", 1'b0, 6'd35, 16'h0000, 3'b000);
    reset = 1'b0;
    #1;
    check("t6_ready_rel", 32'(req_ready), 32'h1);
    tick();
    check_wr("t6_rel", 1'b1, 6'd2, 16'h0002, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
